// File: rtl/lsu_mem_initiator.sv
// Load/store initiator between the rv32i datapath and the word-wide RAM data port.
// Handles sub-word stores by read-modify-write and extends sub-word loads.
module lsu_mem_initiator #(
  parameter int unsigned MEM_SIZE = 16384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RMW_RD = 3'd1;
  localparam logic [2:0] LOAD   = 3'd2;
  localparam logic [2:0] WRITE  = 3'd3;
  localparam logic [2:0] RESP   = 3'd4;

  localparam logic [31:0] LIMIT = 32'(MEM_SIZE - 3);

  logic [2:0]  state;
  logic        wr_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] old_q;
  logic [31:0] res_q;
  logic        fault_q;

  logic        bad_addr;
  logic        bad_f3;
  logic        fault;
  logic [31:0] merged;
  logic [31:0] ext;

  assign bad_addr = req_addr >= LIMIT;

  always_comb begin
    bad_f3 = 1'b0;
    if (req_write) begin
      bad_f3 = req_funct3 > 3'd2;
    end else begin
      unique case (req_funct3)
        3'd0, 3'd1, 3'd2, 3'd4, 3'd5: bad_f3 = 1'b0;
        default:                      bad_f3 = 1'b1;
      endcase
    end
  end

  assign fault = bad_addr | bad_f3;

  always_comb begin
    ext = mem_rdata;
    unique case (f3_q)
      3'd0:    ext = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
      3'd1:    ext = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
      3'd4:    ext = {24'd0, mem_rdata[7:0]};
      3'd5:    ext = {16'd0, mem_rdata[15:0]};
      default: ext = mem_rdata;
    endcase
  end

  // Sub-word stores keep the untouched bytes of the word read in RMW_RD
  always_comb begin
    merged = wdata_q;
    unique case (f3_q[1:0])
      2'd0:    merged = {old_q[31:8], wdata_q[7:0]};
      2'd1:    merged = {old_q[31:16], wdata_q[15:0]};
      default: merged = wdata_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      wr_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      old_q   <= 32'd0;
      res_q   <= 32'd0;
      fault_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            wr_q    <= req_write;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            old_q   <= 32'd0;
            res_q   <= 32'd0;
            fault_q <= fault;
            if (fault)
              state <= RESP;
            else if (!req_write)
              state <= LOAD;
            else if (req_funct3 == 3'd2)
              state <= WRITE;
            else
              state <= RMW_RD;
          end
        end
        LOAD: begin
          res_q <= ext;
          state <= RESP;
        end
        RMW_RD: begin
          old_q <= mem_rdata;
          state <= WRITE;
        end
        WRITE:   state <= RESP;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready  = state == IDLE;
  assign resp_valid = state == RESP;
  assign resp_fault = resp_valid & fault_q;
  assign resp_rdata = resp_valid ? res_q : 32'd0;

  assign mem_read  = (state == LOAD) || (state == RMW_RD);
  assign mem_write = (state == WRITE) && wr_q;
  assign mem_addr  = (mem_read || mem_write) ? addr_q : 32'd0;
  assign mem_wdata = mem_write ? merged : 32'd0;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator with a byte-array RAM model.
// Inputs change at posedge+1, outputs are sampled on the falling edge.
module tb_lsu_mem_initiator;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  lsu_mem_initiator #(.MEM_SIZE(16384)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_fault(resp_fault),
    .mem_addr(mem_addr), .mem_read(mem_read),
    .mem_write(mem_write), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  ram [0:16383];
  logic [13:0] ra;
  assign ra = mem_addr[13:0];
  assign mem_rdata = {ram[ra + 14'd3], ram[ra + 14'd2],
                      ram[ra + 14'd1], ram[ra]};

  always @(posedge clk) begin
    if (mem_write) begin
      ram[ra]         <= mem_wdata[7:0];
      ram[ra + 14'd1] <= mem_wdata[15:8];
      ram[ra + 14'd2] <= mem_wdata[23:16];
      ram[ra + 14'd3] <= mem_wdata[31:24];
    end
  end

  int rd_cnt;
  int wr_cnt;
  int both_cnt;

  always @(negedge clk) begin
    if (mem_read) rd_cnt++;
    if (mem_write) wr_cnt++;
    if (mem_read && mem_write) both_cnt++;
  end

  int pass_cnt;
  int total_cnt;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] word_at(input logic [13:0] a);
    return {ram[a + 14'd3], ram[a + 14'd2], ram[a + 14'd1], ram[a]};
  endfunction

  // Issue one request from IDLE; returns response and latency (-1 on timeout)
  task automatic txn(input logic w, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic flt,
                     output int lat);
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
    rd  = 32'hx;
    flt = 1'bx;
    lat = -1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        rd  = resp_rdata;
        flt = resp_fault;
        lat = i;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  logic [31:0] rd;
  logic        flt;
  int          lat;
  int          acc;
  int          rsp;

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    rd_cnt = 0;
    wr_cnt = 0;
    both_cnt = 0;
    for (int i = 0; i < 16384; i++) ram[i] = 8'h00;
    {ram[16383], ram[16382], ram[16381], ram[16380]} = 32'hCAFEF00D;
    {ram[32'h203], ram[32'h202], ram[32'h201], ram[32'h200]} = 32'h11223344;
    rst = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_funct3 = 3'd0;
    req_addr = 32'd0;
    req_wdata = 32'd0;

    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp", {resp_valid, resp_fault, resp_rdata[29:0]}, 32'd0);
    chk("rst_strobes", {mem_read, mem_write, mem_addr[29:0]}, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Reset while the RMW read of an SB is in flight
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd0;
    req_addr = 32'h200; req_wdata = 32'h55;
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("rmw_rd_read", 32'(mem_read), 32'd1);
    #2 rst = 1'b1;
    #1 chk("rst_drop", {30'd0, mem_read, mem_write}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mid_ready", 32'(req_ready), 32'd1);
    chk("rst_mid_nowr", 32'(wr_cnt), 32'd0);
    chk("rst_mid_ram", word_at(14'h200), 32'h11223344);
    @(posedge clk);
    #1;

    txn(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, rd, flt, lat);
    chk("sw_lat", 32'(lat), 32'd2);
    chk("sw_resp", {rd[30:0], flt}, 32'd0);
    txn(1'b0, 3'd2, 32'h100, 32'd0, rd, flt, lat);
    chk("lw_data", rd, 32'hDEADBEEF);
    chk("lw_lat", 32'(lat), 32'd2);
    chk("lw_fault", 32'(flt), 32'd0);

    rd_cnt = 0; wr_cnt = 0;
    txn(1'b1, 3'd0, 32'h100, 32'h000000AA, rd, flt, lat);
    chk("sb_lat", 32'(lat), 32'd3);
    chk("sb_ram", word_at(14'h100), 32'hDEADBEAA);
    chk("sb_strobes", 32'(rd_cnt * 16 + wr_cnt), 32'h11);
    txn(1'b0, 3'd0, 32'h100, 32'd0, rd, flt, lat);
    chk("lb_data", rd, 32'hFFFFFFAA);
    txn(1'b0, 3'd4, 32'h100, 32'd0, rd, flt, lat);
    chk("lbu_data", rd, 32'h000000AA);

    txn(1'b1, 3'd1, 32'h102, 32'h00008001, rd, flt, lat);
    chk("sh_lat", 32'(lat), 32'd3);
    chk("sh_bytes", {16'd0, ram[32'h103], ram[32'h102]}, 32'h8001);
    chk("sh_word", word_at(14'h100), 32'h8001BEAA);
    txn(1'b0, 3'd1, 32'h102, 32'd0, rd, flt, lat);
    chk("lh_data", rd, 32'hFFFF8001);
    txn(1'b0, 3'd5, 32'h102, 32'd0, rd, flt, lat);
    chk("lhu_data", rd, 32'h00008001);

    txn(1'b0, 3'd2, 32'd16380, 32'd0, rd, flt, lat);
    chk("lw_top_data", rd, 32'hCAFEF00D);
    chk("lw_top_fault", 32'(flt), 32'd0);
    rd_cnt = 0; wr_cnt = 0;
    txn(1'b0, 3'd2, 32'd16381, 32'd0, rd, flt, lat);
    chk("lw_oob_fault", 32'(flt), 32'd1);
    chk("lw_oob_data", rd, 32'd0);
    chk("lw_oob_lat", 32'(lat), 32'd1);
    txn(1'b1, 3'd2, 32'hFFFFFFFC, 32'h12345678, rd, flt, lat);
    chk("sw_oob_fault", 32'(flt), 32'd1);
    chk("sw_oob_lat", 32'(lat), 32'd1);
    chk("oob_strobes", 32'(rd_cnt + wr_cnt), 32'd0);

    txn(1'b0, 3'd3, 32'h100, 32'd0, rd, flt, lat);
    chk("ld_f3_fault", {rd[30:0], flt}, 32'd1);
    txn(1'b1, 3'd4, 32'h100, 32'h0, rd, flt, lat);
    chk("st_f3_fault", {rd[30:0], flt}, 32'd1);
    chk("st_f3_ram", word_at(14'h100), 32'h8001BEAA);
    chk("f3_strobes", 32'(rd_cnt + wr_cnt), 32'd0);

    // Request held high: IDLE/LOAD/RESP repeats, one accept per RESP
    acc = 0;
    rsp = 0;
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd2;
    req_addr = 32'h100; req_wdata = 32'd0;
    repeat (12) begin
      @(negedge clk);
      if (req_valid && req_ready) acc++;
      if (resp_valid) begin
        rsp++;
        chk("held_data", resp_rdata, 32'h8001BEAA);
      end
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("held_accepts", 32'(acc), 32'd4);
    chk("held_resps", 32'(rsp), 32'd4);
    chk("never_both", 32'(both_cnt), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
